// File: rtl/hamming_decoder_pkg.sv
// Shared types, group masks and data-bit layout for the (16,11) SECDED decoder.
// Latency: n/a (package only).
// Backpressure: n/a.
package hamming_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_MSW,
        CALC,
        FIX,
        DONE
    } dec_state_t;

    typedef enum logic [1:0] {
        kOK     = 2'b00,
        kCORR   = 2'b01,
        kUNCORR = 2'b10
    } dec_status_t;

    // Groups 0..3 build syndrome bits 0..3; group 4 covers the whole word for overall parity.
    localparam logic [15:0] kGRP_MASK [5] = '{
        16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00, 16'hFFFF
    };

    localparam logic [3:0] kDATA_POS [11] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    function automatic logic [10:0] extract_data(input logic [15:0] cw);
        logic [10:0] d;
        for (int i = 0; i < 11; i++) begin
            d[i] = cw[kDATA_POS[i]];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_decoder_parity_group.sv
// Reduction parity of the codeword bits selected by one group mask.
// Latency: combinational.
// Backpressure: none.
module hamming_decoder_parity_group (
    input  logic [15:0] cw,
    input  logic [15:0] mask,
    output logic        par
);

    assign par = ^(cw & mask);

endmodule

// File: rtl/hamming_decoder.sv
// Byte-serial (16,11) SECDED decoder: one parity group per cycle, then correct and extract.
// Latency: OUT_VALID 6 cycles after the MSW handshake (5 without overall parity).
// Backpressure: IN_READY low from MSW accept until the result is taken; result held while OUT_READY low.
module hamming_decoder
    import hamming_decoder_pkg::*;
#(
    parameter int OVERALL_PARITY = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [10:0] OUT_DATA,
    output logic [1:0]  OUT_STATUS,
    output logic [3:0]  ERR_POS,
    output logic        OUT_VALID,
    input  logic        OUT_READY
);

    dec_state_t  state;
    logic [15:0] cw;
    logic [3:0]  syn;
    logic        p_all;
    logic [2:0]  grp_k;
    logic [15:0] grp_mask;
    logic        grp_bit;
    logic        last_grp;

    logic        p_eff;
    logic [15:0] fix_cw;
    dec_status_t fix_status;
    logic [3:0]  fix_pos;

    always_comb begin
        grp_mask = 16'h0;
        if (grp_k < 3'd5) begin
            grp_mask = kGRP_MASK[grp_k];
        end
    end

    hamming_decoder_parity_group u_parity_group (
        .cw   (cw),
        .mask (grp_mask),
        .par  (grp_bit)
    );

    // Without the overall-parity group, a nonzero syndrome is always taken as a single error.
    assign last_grp = (OVERALL_PARITY != 0) ? (grp_k == 3'd4) : (grp_k == 3'd3);
    assign p_eff    = (OVERALL_PARITY != 0) ? p_all : (syn != 4'd0);

    always_comb begin
        fix_cw     = cw;
        fix_status = kOK;
        fix_pos    = 4'd0;
        if (p_eff) begin
            fix_cw[syn] = ~cw[syn];
            fix_status  = kCORR;
            fix_pos     = syn;
        end else if (syn != 4'd0) begin
            fix_status = kUNCORR;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            cw         <= 16'h0;
            syn        <= 4'd0;
            p_all      <= 1'b0;
            grp_k      <= 3'd0;
            IN_READY   <= 1'b1;
            OUT_VALID  <= 1'b0;
            OUT_DATA   <= 11'd0;
            OUT_STATUS <= kOK;
            ERR_POS    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        cw[7:0] <= IN_DATA;
                        state   <= GET_MSW;
                    end
                end
                GET_MSW: begin
                    if (IN_VALID) begin
                        cw[15:8] <= IN_DATA;
                        grp_k    <= 3'd0;
                        syn      <= 4'd0;
                        p_all    <= 1'b0;
                        IN_READY <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (grp_k == 3'd4) begin
                        p_all <= grp_bit;
                    end else begin
                        syn[grp_k[1:0]] <= grp_bit;
                    end
                    if (last_grp) begin
                        state <= FIX;
                    end else begin
                        grp_k <= grp_k + 3'd1;
                    end
                end
                FIX: begin
                    OUT_DATA   <= extract_data(fix_cw);
                    OUT_STATUS <= fix_status;
                    ERR_POS    <= fix_pos;
                    OUT_VALID  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
